vga_scan_timer: RTL

Upstream neighbour of the colour palette stage. Generates 640x480@60 VGA raster timing from the 50 MHz Clk using a pixel clock enable. Drives drawX/drawY, which the palette stage uses for its background-ROM address, and the hs, vs and blank_n signals to the DAC pins. Owns palSelect: a requested palette is accepted by handshake and applied only at a frame boundary, so no frame tears.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/sync_delay_line.sv | 44 ++++
 rtl/vga_scan_timer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480@60 timing constants and shared palette code type
//
// Purpose: default raster geometry, derived totals and sync window bounds,
//          the palette code type shared with the palette stage, and a
//          half-open window decode helper used for sync/blank generation.
// Ports:   none (package).
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [2:0] pal_code_t;

  // True when lo <= pos < hi for a 10-bit raster counter.
  function automatic logic in_window(input logic [9:0] pos, input int lo, input int hi);
    return (int'(pos) >= lo) && (int'(pos) < hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - fixed-depth register delay line with a reset pattern
//
// Purpose: delays a bundle of level signals by DEPTH clocks; every stage
//          resets to RESET_VALUE so the output is defined from the first edge.
// Ports:   clk   in   clock
//          reset in   synchronous, active-high reset
//          din   in   [WIDTH] undelayed bundle
//          dout  out  [WIDTH] bundle delayed by DEPTH clocks
module sync_delay_line #(
  parameter int               DEPTH       = 1,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_timer.sv
// rtl/vga_scan_timer.sv - VGA raster timer with frame-synchronous palette select
//
// Purpose: divides Clk into a pixel strobe, scans drawX/drawY over the full
//          raster, decodes registered hs/vs/blank_n, pulses frame_start and
//          counts frames at each raster wrap, and applies a handshaked
//          palette request only at a frame boundary so no frame tears.
// Build option: VGA_PIPE_ALIGN_EN - when defined, hs/vs/blank_n are delayed
//          by SYNC_DELAY Clk through sync_delay_line; drawX/drawY,
//          frame_start and palSelect are never delayed.
// Ports:   Clk            in   system clock
//          Reset          in   synchronous, active-high reset
//          pal_req        in   [3] requested palette code
//          pal_req_valid  in   request valid
//          pal_ready      out  able to accept a request
//          pixel_ce       out  one-Clk pixel strobe
//          drawX          out  [10] horizontal counter
//          drawY          out  [10] vertical counter
//          hs             out  horizontal sync, active low
//          vs             out  vertical sync, active low
//          blank_n        out  high inside the visible region
//          frame_start    out  one-Clk pulse after the raster wraps to (0,0)
//          palSelect      out  [3] palette applied for the current frame
//          frame_count    out  [16] completed frames, wraps modulo 2^16
module vga_scan_timer
  import vga_timing_pkg::*;
#(
  parameter int        H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
  parameter int        H_FP        = vga_timing_pkg::H_FP,
  parameter int        H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int        H_BP        = vga_timing_pkg::H_BP,
  parameter int        V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
  parameter int        V_FP        = vga_timing_pkg::V_FP,
  parameter int        V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int        V_BP        = vga_timing_pkg::V_BP,
  parameter int        CE_DIV      = 2,
  parameter pal_code_t DEFAULT_PAL = 3'b000,
  parameter int        SYNC_DELAY  = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [2:0]  pal_req,
  input  logic        pal_req_valid,
  output logic        pal_ready,
  output logic        pixel_ce,
  output logic [9:0]  drawX,
  output logic [9:0]  drawY,
  output logic        hs,
  output logic        vs,
  output logic        blank_n,
  output logic        frame_start,
  output logic [2:0]  palSelect,
  output logic [15:0] frame_count
);

  localparam int LINE_LEN    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START    = H_VISIBLE + H_FP;
  localparam int HS_END      = HS_START + H_SYNC;
  localparam int VS_START    = V_VISIBLE + V_FP;
  localparam int VS_END      = VS_START + V_SYNC;
  localparam int DIV_W       = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam logic [9:0]       X_LAST   = 10'(LINE_LEN - 1);
  localparam logic [9:0]       Y_LAST   = 10'(FRAME_LINES - 1);

`ifdef VGA_PIPE_ALIGN_EN
  localparam bit PIPE_ALIGN = 1'b1;
`else
  localparam bit PIPE_ALIGN = 1'b0;
`endif
  localparam int PIPE_DEPTH = PIPE_ALIGN ? SYNC_DELAY : 0;

  logic [DIV_W-1:0] div_q, div_d;
  logic             pce_q, pce_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic             fs_q, fs_d;
  logic [15:0]      fc_q, fc_d;
  pal_code_t        pal_q, pal_d, pend_q, pend_d;
  logic             ready_q, ready_d;
  logic             wrap;

  always_comb begin
    // The strobe is registered so it stays low through reset and first
    // rises CE_DIV edges after release.
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    pce_d = (div_q == DIV_LAST);

    x_d  = x_q;
    y_d  = y_q;
    wrap = 1'b0;
    if (pce_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          wrap = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decoded from the next counter values so the registered sync/blank
    // always line up with the registered counters.
    hs_d    = !in_window(x_d, HS_START, HS_END);
    vs_d    = !in_window(y_d, VS_START, VS_END);
    blank_d = in_window(x_d, 0, H_VISIBLE) && in_window(y_d, 0, V_VISIBLE);

    fs_d = wrap;
    fc_d = wrap ? fc_q + 16'd1 : fc_q;

    // pal_ready low means a request is pending. Apply and accept can never
    // coincide, so a request taken on the wrap edge waits a full frame.
    pal_d   = pal_q;
    pend_d  = pend_q;
    ready_d = ready_q;
    if (wrap && !ready_q) begin
      pal_d   = pend_q;
      ready_d = 1'b1;
    end else if (pal_req_valid && ready_q) begin
      pend_d  = pal_req;
      ready_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q   <= '0;
      pce_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
      fc_q    <= '0;
      pal_q   <= DEFAULT_PAL;
      pend_q  <= DEFAULT_PAL;
      ready_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      pce_q   <= pce_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
      pal_q   <= pal_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

  generate
    if (PIPE_DEPTH > 0) begin : g_pipe
      sync_delay_line #(
        .DEPTH       (PIPE_DEPTH),
        .WIDTH       (3),
        .RESET_VALUE (3'b111)
      ) u_sync_delay (
        .clk   (Clk),
        .reset (Reset),
        .din   ({hs_q, vs_q, blank_q}),
        .dout  ({hs, vs, blank_n})
      );
    end else begin : g_direct
      assign hs      = hs_q;
      assign vs      = vs_q;
      assign blank_n = blank_q;
    end
  endgenerate

  assign pixel_ce    = pce_q;
  assign drawX       = x_q;
  assign drawY       = y_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;
  assign palSelect   = pal_q;
  assign pal_ready   = ready_q;

endmodule
